// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: port owner encoding,
// the issued-access bundle and the starvation counter helper.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_AUX  = 2'd2
    } owner_t;

    localparam int STARVE_MAX_DEF = 4;
    localparam int CNT_W          = 4;

    typedef struct packed {
        logic [3:0]  en;
        logic        wea;
        logic        rea;
        logic [31:0] addr;
        logic [31:0] din;
    } mem_req_t;

    localparam mem_req_t MEM_IDLE = '0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of core, aux-master and BRAM signals around the arbiter.
// slave = arbiter view, master = surrounding system (core, aux master, BRAM).
interface dmem_port_arbiter_if;

    logic [3:0]  core_en;
    logic        core_wea;
    logic        core_rea;
    logic [31:0] core_addr;
    logic [31:0] core_din;
    logic [31:0] core_dout;
    logic        mem_hold;

    logic        aux_req;
    logic        aux_we;
    logic [3:0]  aux_be;
    logic [31:0] aux_addr;
    logic [31:0] aux_wdata;
    logic        aux_gnt;
    logic        aux_rvalid;
    logic [31:0] aux_rdata;

    logic [3:0]  mem_en;
    logic        mem_wea;
    logic        mem_rea;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    modport slave (
        input  core_en, core_wea, core_rea, core_addr, core_din,
        input  aux_req, aux_we, aux_be, aux_addr, aux_wdata,
        input  mem_dout,
        output core_dout, mem_hold,
        output aux_gnt, aux_rvalid, aux_rdata,
        output mem_en, mem_wea, mem_rea, mem_addr, mem_din
    );

    modport master (
        output core_en, core_wea, core_rea, core_addr, core_din,
        output aux_req, aux_we, aux_be, aux_addr, aux_wdata,
        output mem_dout,
        input  core_dout, mem_hold,
        input  aux_gnt, aux_rvalid, aux_rdata,
        input  mem_en, mem_wea, mem_rea, mem_addr, mem_din
    );

endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the data BRAM port between the core MEM stage and an aux bus master.
// Core passes through unless aux holds the port; bounded starvation forces aux in.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 Rst,
    dmem_port_arbiter_if.slave   bus
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic             core_req;
    logic             force_aux;
    logic             gnt_aux;
    logic             gnt_core;
    mem_req_t         core_acc;
    mem_req_t         aux_acc;
    mem_req_t         issue;

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    owner_t           prev_own_q, prev_own_d;
    logic             prev_read_q, prev_read_d;

    // Forcing is suppressed right after an aux grant so the core always gets the next slot.
    always_comb begin
        core_req  = (bus.core_en != 4'h0) & (bus.core_wea | bus.core_rea);
        force_aux = (starve_cnt_q == STARVE_LIM) & (prev_own_q != OWN_AUX);
        gnt_aux   = bus.aux_req & (~core_req | force_aux);
        gnt_core  = core_req & ~gnt_aux;
    end

    always_comb begin
        core_acc = '{en:   bus.core_en,
                     wea:  bus.core_wea,
                     rea:  bus.core_rea,
                     addr: bus.core_addr,
                     din:  bus.core_din};
        aux_acc  = '{en:   bus.aux_be,
                     wea:  bus.aux_we,
                     rea:  ~bus.aux_we,
                     addr: bus.aux_addr,
                     din:  bus.aux_wdata};
        issue = MEM_IDLE;
        if (gnt_aux) begin
            issue = aux_acc;
        end else if (gnt_core) begin
            issue = core_acc;
        end
    end

    always_comb begin
        bus.mem_en   = issue.en;
        bus.mem_wea  = issue.wea;
        bus.mem_rea  = issue.rea;
        bus.mem_addr = issue.addr;
        bus.mem_din  = issue.din;
        bus.aux_gnt  = gnt_aux;
        bus.mem_hold = core_req & gnt_aux;
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (gnt_aux || !bus.aux_req) begin
            starve_cnt_d = '0;
        end else if (gnt_core) begin
            starve_cnt_d = sat_inc(starve_cnt_q, STARVE_LIM);
        end

        prev_own_d  = OWN_NONE;
        prev_read_d = 1'b0;
        if (gnt_aux) begin
            prev_own_d  = OWN_AUX;
            prev_read_d = ~bus.aux_we;
        end else if (gnt_core) begin
            prev_own_d  = OWN_CORE;
            prev_read_d = bus.core_rea;
        end
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            starve_cnt_q <= '0;
            prev_own_q   <= OWN_NONE;
            prev_read_q  <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            prev_own_q   <= prev_own_d;
            prev_read_q  <= prev_read_d;
        end
    end

    // BRAM data of the previous cycle's access is steered by who issued it.
    always_comb begin
        bus.core_dout  = bus.mem_dout;
        bus.aux_rvalid = (prev_own_q == OWN_AUX) & prev_read_q;
        bus.aux_rdata  = bus.aux_rvalid ? bus.mem_dout : 32'h0;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: BRAM model, per-cycle reference model of the
// grant/starvation rules, and directed scenarios with hand-computed values.
module tb_dmem_port_arbiter;

    localparam int SM = 4;

    logic clk = 1'b0;
    logic Rst = 1'b0;

    dmem_port_arbiter_if bus();

    dmem_port_arbiter #(.STARVE_MAX(SM)) dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] bram    [0:255] = '{default: '0};
    logic [31:0] ref_mem [0:255] = '{default: '0};

    // Synchronous BRAM with byte-enabled writes and 1-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_en != 4'h0) begin
            if (bus.mem_wea) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_en[b]) bram[bus.mem_addr[9:2]][b*8 +: 8] <= bus.mem_din[b*8 +: 8];
                end
            end
            if (bus.mem_rea) bus.mem_dout <= bram[bus.mem_addr[9:2]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who should own the port this cycle and what returns next cycle.
    int          wait_cnt  = 0;
    bit          last_aux  = 1'b0;
    int          pend      = 0;
    logic [31:0] pend_data = '0;

    initial begin
        forever begin
            logic        creq, ea, ec;
            logic [3:0]  een;
            logic        ewe, ere;
            logic [31:0] eaddr, edin;
            @(negedge clk);
            if (!Rst) begin
                chk("m_rst_rvalid", 32'(bus.aux_rvalid), 32'd0);
                chk("m_rst_rdata", bus.aux_rdata, 32'd0);
                wait_cnt = 0;
                last_aux = 1'b0;
                pend     = 0;
            end else begin
                if (pend == 2) begin
                    chk("m_rvalid", 32'(bus.aux_rvalid), 32'd1);
                    chk("m_rdata", bus.aux_rdata, pend_data);
                end else begin
                    chk("m_rvalid", 32'(bus.aux_rvalid), 32'd0);
                    chk("m_rdata", bus.aux_rdata, 32'd0);
                end
                if (pend == 1) chk("m_core_dout", bus.core_dout, pend_data);

                creq = (bus.core_en != 4'h0) && (bus.core_wea || bus.core_rea);
                ea   = bus.aux_req && (!creq || (wait_cnt >= SM && !last_aux));
                ec   = creq && !ea;
                een = 4'h0; ewe = 1'b0; ere = 1'b0; eaddr = '0; edin = '0;
                if (ea) begin
                    een = bus.aux_be; ewe = bus.aux_we; ere = !bus.aux_we;
                    eaddr = bus.aux_addr; edin = bus.aux_wdata;
                end else if (ec) begin
                    een = bus.core_en; ewe = bus.core_wea; ere = bus.core_rea;
                    eaddr = bus.core_addr; edin = bus.core_din;
                end
                chk("m_gnt", 32'(bus.aux_gnt), 32'(ea));
                chk("m_hold", 32'(bus.mem_hold), 32'(creq && ea));
                chk("m_en", 32'(bus.mem_en), 32'(een));
                chk("m_wea", 32'(bus.mem_wea), 32'(ewe));
                chk("m_rea", 32'(bus.mem_rea), 32'(ere));
                chk("m_addr", bus.mem_addr, eaddr);
                chk("m_din", bus.mem_din, edin);

                pend = 0;
                if (ere && een != 4'h0) begin
                    pend      = ea ? 2 : 1;
                    pend_data = ref_mem[eaddr[9:2]];
                end
                if (ewe) begin
                    for (int b = 0; b < 4; b++) begin
                        if (een[b]) ref_mem[eaddr[9:2]][b*8 +: 8] = edin[b*8 +: 8];
                    end
                end
                if (ea || !bus.aux_req) wait_cnt = 0;
                else if (ec && wait_cnt < SM) wait_cnt++;
                last_aux = ea;
            end
        end
    end

    task automatic idle();
        bus.core_en = 4'h0; bus.core_wea = 1'b0; bus.core_rea = 1'b0;
        bus.core_addr = '0; bus.core_din = '0;
        bus.aux_req = 1'b0; bus.aux_we = 1'b0; bus.aux_be = 4'h0;
        bus.aux_addr = '0; bus.aux_wdata = '0;
    endtask

    task automatic core_rd(input logic [31:0] a);
        bus.core_en = 4'hF; bus.core_wea = 1'b0; bus.core_rea = 1'b1;
        bus.core_addr = a; bus.core_din = '0;
    endtask

    task automatic core_wr(input logic [31:0] a, input logic [31:0] d);
        bus.core_en = 4'hF; bus.core_wea = 1'b1; bus.core_rea = 1'b0;
        bus.core_addr = a; bus.core_din = d;
    endtask

    task automatic aux_set(input logic we, input logic [3:0] be, input logic [31:0] a,
                           input logic [31:0] d);
        bus.aux_req = 1'b1; bus.aux_we = we; bus.aux_be = be;
        bus.aux_addr = a; bus.aux_wdata = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        idle();
        Rst = 1'b0;
        repeat (2) @(posedge clk);
        sample();
        chk("reset_rvalid", 32'(bus.aux_rvalid), 32'd0);
        chk("reset_rdata", bus.aux_rdata, 32'd0);
        chk("reset_hold", 32'(bus.mem_hold), 32'd0);
        next_cycle();
        Rst = 1'b1;

        // Core-only traffic
        next_cycle(); core_rd(32'h100); sample();
        chk("t1_rd_addr", bus.mem_addr, 32'h100);
        chk("t1_rd_rea", 32'(bus.mem_rea), 32'd1);
        chk("t1_hold", 32'(bus.mem_hold), 32'd0);
        next_cycle(); core_wr(32'h100, 32'hDEADBEEF); sample();
        chk("t1_rd_data", bus.core_dout, 32'h0);
        chk("t1_wr_din", bus.mem_din, 32'hDEADBEEF);
        chk("t1_wr_en", 32'(bus.mem_en), 32'hF);
        next_cycle(); core_rd(32'h100); sample();
        chk("t1_hold2", 32'(bus.mem_hold), 32'd0);
        next_cycle(); idle(); sample();
        chk("t1_readback", bus.core_dout, 32'hDEADBEEF);
        chk("t1_idle_en", 32'(bus.mem_en), 32'd0);

        // Aux on an idle port
        next_cycle(); aux_set(1'b1, 4'hF, 32'h200, 32'h12345678); sample();
        chk("t2_wr_gnt", 32'(bus.aux_gnt), 32'd1);
        next_cycle(); aux_set(1'b0, 4'hF, 32'h200, 32'h0); sample();
        chk("t2_rd_gnt", 32'(bus.aux_gnt), 32'd1);
        chk("t2_rd_hold", 32'(bus.mem_hold), 32'd0);
        next_cycle(); idle(); sample();
        chk("t2_rvalid", 32'(bus.aux_rvalid), 32'd1);
        chk("t2_rdata", bus.aux_rdata, 32'h12345678);
        next_cycle(); sample();
        chk("t2_rvalid_pulse", 32'(bus.aux_rvalid), 32'd0);

        // Starvation under continuous core reads
        for (int i = 0; i < 8; i++) begin
            next_cycle(); core_rd(32'h100); aux_set(1'b0, 4'hF, 32'h200, 32'h0); sample();
            chk("t3_gnt", 32'(bus.aux_gnt), 32'(i == 4));
            chk("t3_hold", 32'(bus.mem_hold), 32'(i == 4));
            if (i == 5) begin
                chk("t3_core_after", bus.mem_addr, 32'h100);
                chk("t3_rdata", bus.aux_rdata, 32'h12345678);
            end
        end
        next_cycle(); idle(); sample();

        // Conflicting writes to 0x40 with the counter saturated
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            if (i < 4) core_rd(32'h100); else core_wr(32'h40, 32'h22222222);
            if (i <= 4) aux_set(1'b1, 4'hF, 32'h40, 32'h11111111); else bus.aux_req = 1'b0;
            sample();
            if (i == 4) begin
                chk("t4_aux_first", 32'(bus.aux_gnt), 32'd1);
                chk("t4_aux_din", bus.mem_din, 32'h11111111);
            end
            if (i == 5) begin
                chk("t4_core_next", bus.mem_din, 32'h22222222);
                chk("t4_core_hold", 32'(bus.mem_hold), 32'd0);
            end
        end
        next_cycle(); idle(); aux_set(1'b0, 4'hF, 32'h40, 32'h0); sample();
        next_cycle(); idle(); sample();
        chk("t4_final", bus.aux_rdata, 32'h22222222);

        // Byte enables
        next_cycle(); aux_set(1'b1, 4'b0010, 32'h0, 32'hAABBCCDD); sample();
        chk("t5_en", 32'(bus.mem_en), 32'h2);
        next_cycle(); aux_set(1'b0, 4'hF, 32'h0, 32'h0); sample();
        next_cycle(); idle(); sample();
        chk("t5_readback", bus.aux_rdata, 32'h0000CC00);

        // Reset while an aux read is in flight
        next_cycle(); aux_set(1'b0, 4'hF, 32'h200, 32'h0); sample();
        chk("t6_gnt", 32'(bus.aux_gnt), 32'd1);
        next_cycle(); Rst = 1'b0; sample();
        chk("t6_dropped", 32'(bus.aux_rvalid), 32'd0);
        next_cycle(); Rst = 1'b1; sample();
        chk("t6_regnt", 32'(bus.aux_gnt), 32'd1);
        chk("t6_no_rvalid", 32'(bus.aux_rvalid), 32'd0);
        next_cycle(); idle(); sample();
        chk("t6_rdata", bus.aux_rdata, 32'h12345678);

        // Reset clears a partially built starvation count
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            core_rd(32'h100); aux_set(1'b0, 4'hF, 32'h200, 32'h0);
            if (i == 3) Rst = 1'b0;
            if (i == 4) Rst = 1'b1;
            sample();
            if (i >= 4) chk("t7_gnt", 32'(bus.aux_gnt), 32'(i == 8));
        end
        next_cycle(); idle(); sample();
        next_cycle(); sample();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

endmodule
